// File: rtl/ps_axi_burst_splitter.sv
// Re-issues upstream AXI4 bursts as single-beat downstream transactions and merges the responses.
// Optional macro PS_AXI_SPLIT_WRAP_EN enables true WRAP address sequencing (else WRAP acts as INCR).
module ps_axi_burst_splitter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 12
) (
  input  logic                clock,
  input  logic                reset,
  // upstream read address / data
  input  logic                s_ar_valid,
  input  logic [ADDR_W-1:0]   s_ar_addr,
  input  logic [7:0]          s_ar_len,
  input  logic [2:0]          s_ar_size,
  input  logic [1:0]          s_ar_burst,
  input  logic [ID_W-1:0]     s_ar_id,
  output logic                s_ar_ready,
  output logic                s_r_valid,
  output logic [DATA_W-1:0]   s_r_data,
  output logic [1:0]          s_r_resp,
  output logic [ID_W-1:0]     s_r_id,
  output logic                s_r_last,
  input  logic                s_r_ready,
  // upstream write address / data / response
  input  logic                s_aw_valid,
  input  logic [ADDR_W-1:0]   s_aw_addr,
  input  logic [7:0]          s_aw_len,
  input  logic [2:0]          s_aw_size,
  input  logic [1:0]          s_aw_burst,
  input  logic [ID_W-1:0]     s_aw_id,
  output logic                s_aw_ready,
  input  logic                s_w_valid,
  input  logic [DATA_W-1:0]   s_w_data,
  input  logic [DATA_W/8-1:0] s_w_strb,
  input  logic                s_w_last,
  output logic                s_w_ready,
  output logic                s_b_valid,
  output logic [1:0]          s_b_resp,
  output logic [ID_W-1:0]     s_b_id,
  input  logic                s_b_ready,
  // downstream read address / data
  output logic                m_ar_valid,
  output logic [ADDR_W-1:0]   m_ar_addr,
  output logic [7:0]          m_ar_len,
  output logic [2:0]          m_ar_size,
  output logic [1:0]          m_ar_burst,
  output logic [ID_W-1:0]     m_ar_id,
  input  logic                m_ar_ready,
  input  logic                m_r_valid,
  input  logic [DATA_W-1:0]   m_r_data,
  input  logic [1:0]          m_r_resp,
  input  logic [ID_W-1:0]     m_r_id,
  input  logic                m_r_last,
  output logic                m_r_ready,
  // downstream write address / data / response
  output logic                m_aw_valid,
  output logic [ADDR_W-1:0]   m_aw_addr,
  output logic [7:0]          m_aw_len,
  output logic [2:0]          m_aw_size,
  output logic [1:0]          m_aw_burst,
  output logic [ID_W-1:0]     m_aw_id,
  input  logic                m_aw_ready,
  output logic                m_w_valid,
  output logic [DATA_W-1:0]   m_w_data,
  output logic [DATA_W/8-1:0] m_w_strb,
  output logic                m_w_last,
  input  logic                m_w_ready,
  input  logic                m_b_valid,
  input  logic [1:0]          m_b_resp,
  input  logic [ID_W-1:0]     m_b_id,
  output logic                m_b_ready,
  output logic                protocol_err
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_RET} rstate_t;
  typedef enum logic [2:0] {W_IDLE, W_AW, W_WCAP, W_WPUSH, W_B, W_RESP} wstate_t;

  function automatic logic [ADDR_W-1:0] f_next_addr(
    input logic [ADDR_W-1:0] addr,
    input logic [2:0]        size,
    input logic [1:0]        burst
`ifdef PS_AXI_SPLIT_WRAP_EN
    , input logic [7:0]      len
`endif
  );
    logic [ADDR_W-1:0] incr;
`ifdef PS_AXI_SPLIT_WRAP_EN
    logic [ADDR_W-1:0] mask;
`endif
    incr = addr + (ADDR_W'(1) << size);
    if (burst == 2'b00) return addr;
`ifdef PS_AXI_SPLIT_WRAP_EN
    mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    if (burst == 2'b10) return (addr & ~mask) | (incr & mask);
`endif
    return incr;
  endfunction

  // ---------------- read path ----------------
  rstate_t           r_rstate, w_rstate_nxt;
  logic [ADDR_W-1:0] r_ar_addr;
  logic [7:0]        r_ar_len, r_rcnt;
  logic [2:0]        r_ar_size;
  logic [1:0]        r_ar_burst, r_rresp;
  logic [ID_W-1:0]   r_ar_id;
  logic [DATA_W-1:0] r_rdata;
  logic              w_ar_hs, w_mr_hs, w_sr_hs, w_rfinal;
  logic [ADDR_W-1:0] w_ar_next;

  assign w_ar_hs  = s_ar_valid & s_ar_ready;
  assign w_mr_hs  = m_r_valid & m_r_ready;
  assign w_sr_hs  = s_r_valid & s_r_ready;
  assign w_rfinal = (r_rcnt == r_ar_len);
`ifdef PS_AXI_SPLIT_WRAP_EN
  assign w_ar_next = f_next_addr(r_ar_addr, r_ar_size, r_ar_burst, r_ar_len);
`else
  assign w_ar_next = f_next_addr(r_ar_addr, r_ar_size, r_ar_burst);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_rstate <= R_IDLE;
    else       r_rstate <= w_rstate_nxt;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    s_ar_ready   = 1'b0;
    m_ar_valid   = 1'b0;
    m_r_ready    = 1'b0;
    s_r_valid    = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        // Ready is held low while reset is asserted even though the state already reads IDLE.
        s_ar_ready = ~reset;
        if (w_ar_hs) w_rstate_nxt = R_ISSUE;
      end
      R_ISSUE: begin
        m_ar_valid = 1'b1;
        if (m_ar_ready) w_rstate_nxt = R_WAIT;
      end
      R_WAIT: begin
        m_r_ready = 1'b1;
        if (m_r_valid) w_rstate_nxt = R_RET;
      end
      R_RET: begin
        s_r_valid = 1'b1;
        if (s_r_ready) w_rstate_nxt = w_rfinal ? R_IDLE : R_ISSUE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ar_addr  <= '0;
      r_ar_len   <= '0;
      r_ar_size  <= '0;
      r_ar_burst <= '0;
      r_ar_id    <= '0;
      r_rcnt     <= '0;
      r_rdata    <= '0;
      r_rresp    <= '0;
    end else begin
      if (w_ar_hs) begin
        r_ar_addr  <= s_ar_addr;
        r_ar_len   <= s_ar_len;
        r_ar_size  <= s_ar_size;
        r_ar_burst <= s_ar_burst;
        r_ar_id    <= s_ar_id;
        r_rcnt     <= '0;
      end
      if (w_mr_hs) begin
        r_rdata <= m_r_data;
        r_rresp <= m_r_resp;
      end
      if (w_sr_hs && !w_rfinal) begin
        r_ar_addr <= w_ar_next;
        r_rcnt    <= r_rcnt + 8'd1;
      end
    end
  end

  assign m_ar_addr  = r_ar_addr;
  assign m_ar_len   = 8'd0;
  assign m_ar_size  = r_ar_size;
  assign m_ar_burst = 2'b01;
  assign m_ar_id    = r_ar_id;
  assign s_r_data   = r_rdata;
  assign s_r_resp   = r_rresp;
  assign s_r_id     = r_ar_id;
  assign s_r_last   = w_rfinal;

  // ---------------- write path ----------------
  wstate_t           r_wstate, w_wstate_nxt;
  logic [ADDR_W-1:0] r_aw_addr;
  logic [7:0]        r_aw_len, r_wcnt;
  logic [2:0]        r_aw_size;
  logic [1:0]        r_aw_burst, r_bacc;
  logic [ID_W-1:0]   r_aw_id;
  logic [DATA_W-1:0] r_wdata;
  logic [STRB_W-1:0] r_wstrb;
  logic              r_perr;
  logic              w_aw_hs, w_w_hs, w_mb_hs, w_wfinal;
  logic [ADDR_W-1:0] w_aw_next;

  assign w_aw_hs  = s_aw_valid & s_aw_ready;
  assign w_w_hs   = s_w_valid & s_w_ready;
  assign w_mb_hs  = m_b_valid & m_b_ready;
  assign w_wfinal = (r_wcnt == r_aw_len);
`ifdef PS_AXI_SPLIT_WRAP_EN
  assign w_aw_next = f_next_addr(r_aw_addr, r_aw_size, r_aw_burst, r_aw_len);
`else
  assign w_aw_next = f_next_addr(r_aw_addr, r_aw_size, r_aw_burst);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_wstate <= W_IDLE;
    else       r_wstate <= w_wstate_nxt;
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    s_aw_ready   = 1'b0;
    m_aw_valid   = 1'b0;
    s_w_ready    = 1'b0;
    m_w_valid    = 1'b0;
    m_b_ready    = 1'b0;
    s_b_valid    = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        s_aw_ready = ~reset;
        if (w_aw_hs) w_wstate_nxt = W_AW;
      end
      W_AW: begin
        m_aw_valid = 1'b1;
        if (m_aw_ready) w_wstate_nxt = W_WCAP;
      end
      W_WCAP: begin
        s_w_ready = 1'b1;
        if (s_w_valid) w_wstate_nxt = W_WPUSH;
      end
      W_WPUSH: begin
        m_w_valid = 1'b1;
        if (m_w_ready) w_wstate_nxt = W_B;
      end
      W_B: begin
        m_b_ready = 1'b1;
        if (m_b_valid) w_wstate_nxt = w_wfinal ? W_RESP : W_AW;
      end
      W_RESP: begin
        s_b_valid = 1'b1;
        if (s_b_ready) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_aw_addr  <= '0;
      r_aw_len   <= '0;
      r_aw_size  <= '0;
      r_aw_burst <= '0;
      r_aw_id    <= '0;
      r_wcnt     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bacc     <= '0;
      r_perr     <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_aw_addr  <= s_aw_addr;
        r_aw_len   <= s_aw_len;
        r_aw_size  <= s_aw_size;
        r_aw_burst <= s_aw_burst;
        r_aw_id    <= s_aw_id;
        r_wcnt     <= '0;
        r_bacc     <= '0;
      end
      if (w_w_hs) begin
        r_wdata <= s_w_data;
        r_wstrb <= s_w_strb;
        // The beat count from len stays authoritative; a wrong wlast is only flagged.
        if (s_w_last != w_wfinal) r_perr <= 1'b1;
      end
      if (w_mb_hs) begin
        // Resp encodings order by severity numerically: DECERR > SLVERR > EXOKAY > OKAY.
        if (m_b_resp > r_bacc) r_bacc <= m_b_resp;
        if (!w_wfinal) begin
          r_aw_addr <= w_aw_next;
          r_wcnt    <= r_wcnt + 8'd1;
        end
      end
    end
  end

  assign m_aw_addr    = r_aw_addr;
  assign m_aw_len     = 8'd0;
  assign m_aw_size    = r_aw_size;
  assign m_aw_burst   = 2'b01;
  assign m_aw_id      = r_aw_id;
  assign m_w_data     = r_wdata;
  assign m_w_strb     = r_wstrb;
  assign m_w_last     = 1'b1;
  assign s_b_resp     = r_bacc;
  assign s_b_id       = r_aw_id;
  assign protocol_err = r_perr;

  // Downstream IDs and rlast carry no information for single-beat transactions.
  logic w_unused;
  assign w_unused = ^{m_r_id, m_r_last, m_b_id};

endmodule

// File: tb/tb_ps_axi_burst_splitter.sv
// Directed self-checking bench for ps_axi_burst_splitter; honours PS_AXI_SPLIT_WRAP_EN for WRAP expectations.
module tb_ps_axi_burst_splitter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        s_ar_valid = 1'b0;
  logic [31:0] s_ar_addr = '0;
  logic [7:0]  s_ar_len = '0;
  logic [2:0]  s_ar_size = '0;
  logic [1:0]  s_ar_burst = '0;
  logic [11:0] s_ar_id = '0;
  logic        s_ar_ready;
  logic        s_r_valid;
  logic [31:0] s_r_data;
  logic [1:0]  s_r_resp;
  logic [11:0] s_r_id;
  logic        s_r_last;
  logic        s_r_ready = 1'b1;
  logic        s_aw_valid = 1'b0;
  logic [31:0] s_aw_addr = '0;
  logic [7:0]  s_aw_len = '0;
  logic [2:0]  s_aw_size = '0;
  logic [1:0]  s_aw_burst = '0;
  logic [11:0] s_aw_id = '0;
  logic        s_aw_ready;
  logic        s_w_valid = 1'b0;
  logic [31:0] s_w_data = '0;
  logic [3:0]  s_w_strb = '0;
  logic        s_w_last = 1'b0;
  logic        s_w_ready;
  logic        s_b_valid;
  logic [1:0]  s_b_resp;
  logic [11:0] s_b_id;
  logic        s_b_ready = 1'b1;
  logic        m_ar_valid;
  logic [31:0] m_ar_addr;
  logic [7:0]  m_ar_len;
  logic [2:0]  m_ar_size;
  logic [1:0]  m_ar_burst;
  logic [11:0] m_ar_id;
  logic        m_r_ready;
  logic [31:0] m_r_data = '0;
  logic [1:0]  m_r_resp = 2'b00;
  logic        m_aw_valid;
  logic [31:0] m_aw_addr;
  logic [7:0]  m_aw_len;
  logic [2:0]  m_aw_size;
  logic [1:0]  m_aw_burst;
  logic [11:0] m_aw_id;
  logic        m_w_valid;
  logic [31:0] m_w_data;
  logic [3:0]  m_w_strb;
  logic        m_w_last;
  logic        m_b_ready;
  logic        b_en = 1'b1;
  logic [1:0]  m_b_resp;
  logic        protocol_err;

  logic [1:0]  bresp_tab [64];
  int          b_idx = 0;
  logic [31:0] ar_q [$];
  logic [31:0] aw_q [$];
  logic [31:0] w_q [$];
  int          ar_fmt_bad = 0, aw_fmt_bad = 0, wlast_bad = 0;
  logic [11:0] last_ar_id = '0, last_aw_id = '0;
  logic [2:0]  last_ar_size = '0, last_aw_size = '0;
  logic [3:0]  last_w_strb = '0;
  logic [31:0] exp_addr [8];
  int          total = 0, bad = 0;

  assign m_b_resp = bresp_tab[b_idx[5:0]];

  ps_axi_burst_splitter #(.ADDR_W(32), .DATA_W(32), .ID_W(12)) dut (
    .clock(clock), .reset(reset),
    .s_ar_valid(s_ar_valid), .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len), .s_ar_size(s_ar_size),
    .s_ar_burst(s_ar_burst), .s_ar_id(s_ar_id), .s_ar_ready(s_ar_ready),
    .s_r_valid(s_r_valid), .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_id(s_r_id),
    .s_r_last(s_r_last), .s_r_ready(s_r_ready),
    .s_aw_valid(s_aw_valid), .s_aw_addr(s_aw_addr), .s_aw_len(s_aw_len), .s_aw_size(s_aw_size),
    .s_aw_burst(s_aw_burst), .s_aw_id(s_aw_id), .s_aw_ready(s_aw_ready),
    .s_w_valid(s_w_valid), .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_last(s_w_last),
    .s_w_ready(s_w_ready),
    .s_b_valid(s_b_valid), .s_b_resp(s_b_resp), .s_b_id(s_b_id), .s_b_ready(s_b_ready),
    .m_ar_valid(m_ar_valid), .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len), .m_ar_size(m_ar_size),
    .m_ar_burst(m_ar_burst), .m_ar_id(m_ar_id), .m_ar_ready(1'b1),
    .m_r_valid(1'b1), .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_id(m_ar_id),
    .m_r_last(1'b1), .m_r_ready(m_r_ready),
    .m_aw_valid(m_aw_valid), .m_aw_addr(m_aw_addr), .m_aw_len(m_aw_len), .m_aw_size(m_aw_size),
    .m_aw_burst(m_aw_burst), .m_aw_id(m_aw_id), .m_aw_ready(1'b1),
    .m_w_valid(m_w_valid), .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_last(m_w_last),
    .m_w_ready(1'b1),
    .m_b_valid(b_en), .m_b_resp(m_b_resp), .m_b_id(m_aw_id), .m_b_ready(m_b_ready),
    .protocol_err(protocol_err)
  );

  always #5 clock = ~clock;

  // Downstream slave: logs every handshake; read data is derived from the issued address.
  always @(posedge clock) begin
    if (m_ar_valid) begin
      ar_q.push_back(m_ar_addr);
      m_r_data     <= 32'hA500_0000 | {8'h00, m_ar_addr[23:0]};
      last_ar_id   <= m_ar_id;
      last_ar_size <= m_ar_size;
      if (m_ar_len != 8'd0 || m_ar_burst != 2'b01) ar_fmt_bad <= ar_fmt_bad + 1;
    end
    if (m_aw_valid) begin
      aw_q.push_back(m_aw_addr);
      last_aw_id   <= m_aw_id;
      last_aw_size <= m_aw_size;
      if (m_aw_len != 8'd0 || m_aw_burst != 2'b01) aw_fmt_bad <= aw_fmt_bad + 1;
    end
    if (m_w_valid) begin
      w_q.push_back(m_w_data);
      last_w_strb <= m_w_strb;
      if (!m_w_last) wlast_bad <= wlast_bad + 1;
    end
    if (b_en && m_b_ready) b_idx <= b_idx + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ar_send(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [11:0] id);
    s_ar_addr = addr; s_ar_len = len; s_ar_size = size; s_ar_burst = burst; s_ar_id = id;
    s_ar_valid = 1'b1;
    for (int k = 0; k < 20 && s_ar_ready !== 1'b1; k++) @(negedge clock);
    check("ar_ready", 32'(s_ar_ready), 32'd1);
    @(posedge clock);
    @(negedge clock);
    s_ar_valid = 1'b0;
    check("m_ar_latency", 32'(m_ar_valid), 32'd1);
  endtask

  // Collects n read beats; ar_base is the ar_q index of this burst's first downstream AR.
  task automatic r_collect(input int n, input logic [11:0] id, input logic [1:0] resp,
                           input int ar_base);
    s_r_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 20 && s_r_valid !== 1'b1; k++) @(negedge clock);
      check("r_valid", 32'(s_r_valid), 32'd1);
      check("r_data", s_r_data, 32'hA500_0000 | {8'h00, exp_addr[i][23:0]});
      check("r_id", 32'(s_r_id), 32'(id));
      check("r_resp", 32'(s_r_resp), 32'(resp));
      check("r_last", 32'(s_r_last), 32'(i == n - 1));
      @(posedge clock);
      @(negedge clock);
    end
    check("ar_count", 32'(ar_q.size() - ar_base), 32'(n));
    for (int i = 0; i < n; i++) check("m_ar_addr", ar_q[ar_base + i], exp_addr[i]);
    check("ar_fmt", 32'(ar_fmt_bad), 32'd0);
    check("m_ar_id", 32'(last_ar_id), 32'(id));
  endtask

  task automatic aw_send(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic [11:0] id);
    s_aw_addr = addr; s_aw_len = len; s_aw_size = 3'd2; s_aw_burst = burst; s_aw_id = id;
    s_aw_valid = 1'b1;
    for (int k = 0; k < 20 && s_aw_ready !== 1'b1; k++) @(negedge clock);
    check("aw_ready", 32'(s_aw_ready), 32'd1);
    @(posedge clock);
    @(negedge clock);
    s_aw_valid = 1'b0;
    check("m_aw_latency", 32'(m_aw_valid), 32'd1);
  endtask

  task automatic wr_burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [11:0] id, input bit bad_last, input logic [1:0] exp_resp);
    int aw_base = aw_q.size();
    int w_base  = w_q.size();
    aw_send(addr, len, burst, id);
    for (int i = 0; i <= int'(len); i++) begin
      s_w_valid = 1'b1;
      s_w_data  = 32'hC0DE_0000 + i;
      s_w_strb  = 4'hF;
      s_w_last  = bad_last ? (i == 0) : (i == int'(len));
      for (int k = 0; k < 20 && s_w_ready !== 1'b1; k++) @(negedge clock);
      check("w_ready", 32'(s_w_ready), 32'd1);
      @(posedge clock);
      @(negedge clock);
      s_w_valid = 1'b0;
      check("m_w_latency", 32'(m_w_valid), 32'd1);
      if (bad_last) check("perr_set", 32'(protocol_err), 32'd1);
    end
    for (int k = 0; k < 20 && s_b_valid !== 1'b1; k++) @(negedge clock);
    check("b_valid", 32'(s_b_valid), 32'd1);
    check("b_resp", 32'(s_b_resp), 32'(exp_resp));
    check("b_id", 32'(s_b_id), 32'(id));
    @(posedge clock);
    @(negedge clock);
    check("b_single", 32'(s_b_valid), 32'd0);
    check("aw_count", 32'(aw_q.size() - aw_base), 32'(len) + 32'd1);
    for (int i = 0; i <= int'(len); i++) begin
      check("m_aw_addr", aw_q[aw_base + i], exp_addr[i]);
      check("m_w_data", w_q[w_base + i], 32'hC0DE_0000 + i);
    end
    check("aw_fmt", 32'(aw_fmt_bad), 32'd0);
    check("w_last", 32'(wlast_bad), 32'd0);
    check("m_aw_id", 32'(last_aw_id), 32'(id));
  endtask

  initial begin
    int base;
    for (int i = 0; i < 64; i++) bresp_tab[i] = 2'b00;

    // reset state
    @(negedge clock);
    check("rst_readies", {28'd0, s_ar_ready, s_aw_ready, s_w_ready, m_r_ready}, 32'd0);
    check("rst_valids", {26'd0, m_ar_valid, m_aw_valid, m_w_valid, s_r_valid, s_b_valid, m_b_ready},
          32'd0);
    check("rst_perr", 32'(protocol_err), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("rel_ar_ready", 32'(s_ar_ready), 32'd1);
    check("rel_aw_ready", 32'(s_aw_ready), 32'd1);

    // INCR read
    base = ar_q.size();
    exp_addr[0] = 32'h1000; exp_addr[1] = 32'h1004; exp_addr[2] = 32'h1008; exp_addr[3] = 32'h100C;
    ar_send(32'h1000, 8'd3, 3'd2, 2'b01, 12'h5A5);
    r_collect(4, 12'h5A5, 2'b00, base);
    check("m_ar_size", 32'(last_ar_size), 32'd2);

    // FIXED write
    exp_addr[0] = 32'h2000; exp_addr[1] = 32'h2000;
    wr_burst(32'h2000, 8'd1, 2'b00, 12'h0A1, 1'b0, 2'b00);
    check("m_w_strb", 32'(last_w_strb), 32'hF);
    check("m_aw_size", 32'(last_aw_size), 32'd2);

    // response merge: OKAY, SLVERR, OKAY
    bresp_tab[b_idx + 1] = 2'b10;
    exp_addr[0] = 32'h4000; exp_addr[1] = 32'h4004; exp_addr[2] = 32'h4008;
    wr_burst(32'h4000, 8'd2, 2'b01, 12'h3C3, 1'b0, 2'b10);

    // WRAP read, with a non-OKAY resp passed through per beat
    base = ar_q.size();
    m_r_resp = 2'b01;
`ifdef PS_AXI_SPLIT_WRAP_EN
    exp_addr[0] = 32'h3038; exp_addr[1] = 32'h3020; exp_addr[2] = 32'h3028; exp_addr[3] = 32'h3030;
`else
    exp_addr[0] = 32'h3038; exp_addr[1] = 32'h3040; exp_addr[2] = 32'h3048; exp_addr[3] = 32'h3050;
`endif
    ar_send(32'h3038, 8'd3, 3'd3, 2'b10, 12'h777);
    r_collect(4, 12'h777, 2'b01, base);
    m_r_resp = 2'b00;

    // wlast error: still three beats and a response
    check("perr_clear", 32'(protocol_err), 32'd0);
    exp_addr[0] = 32'h5100; exp_addr[1] = 32'h5104; exp_addr[2] = 32'h5108;
    wr_burst(32'h5100, 8'd2, 2'b01, 12'h0E0, 1'b1, 2'b00);
    repeat (3) @(negedge clock);
    check("perr_held", 32'(protocol_err), 32'd1);

    // read backpressure: s_r_ready low for 10 cycles on the first beat
    base = ar_q.size();
    s_r_ready = 1'b0;
    exp_addr[0] = 32'h5000; exp_addr[1] = 32'h5004; exp_addr[2] = 32'h5008; exp_addr[3] = 32'h500C;
    ar_send(32'h5000, 8'd3, 3'd2, 2'b01, 12'h123);
    for (int k = 0; k < 20 && s_r_valid !== 1'b1; k++) @(negedge clock);
    for (int c = 0; c < 10; c++) begin
      check("stall_valid", 32'(s_r_valid), 32'd1);
      check("stall_data", s_r_data, 32'hA500_5000);
      @(negedge clock);
    end
    check("stall_no_issue", 32'(ar_q.size() - base), 32'd1);
    r_collect(4, 12'h123, 2'b00, base);

    // reset while the write path sits in W_B
    b_en = 1'b0;
    aw_send(32'h6000, 8'd1, 2'b01, 12'h0FF);
    s_w_valid = 1'b1; s_w_data = 32'h1234_5678; s_w_strb = 4'hF; s_w_last = 1'b0;
    for (int k = 0; k < 20 && s_w_ready !== 1'b1; k++) @(negedge clock);
    @(posedge clock);
    @(negedge clock);
    s_w_valid = 1'b0;
    for (int k = 0; k < 20 && m_b_ready !== 1'b1; k++) @(negedge clock);
    check("in_w_b", 32'(m_b_ready), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_valids",
          {23'd0, s_ar_ready, s_aw_ready, s_w_ready, m_r_ready, m_ar_valid, m_aw_valid, m_w_valid,
           s_r_valid, s_b_valid} | {31'd0, m_b_ready}, 32'd0);
    b_en = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rel2_aw_ready", 32'(s_aw_ready), 32'd1);
    check("rel2_perr", 32'(protocol_err), 32'd0);
    check("rel2_no_b", 32'(s_b_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps_axi_burst_splitter.md
# ps_axi_burst_splitter

- Sits between the Zynq PS general-purpose AXI master (32-bit data, 12-bit IDs) and the ps_axi_slave port of Top.
- Accepts arbitrary AXI4 bursts (len 0–255; FIXED, INCR, WRAP) and re-issues each one downstream as a sequence of single-beat (len=0) transactions.
- Reassembles downstream responses into one AXI-compliant burst response upstream: R beats with a correct rlast, one merged B.
- Slave-side logic therefore only needs to handle single beats.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (strobe width DATA_W/8)
- ID_W, 12, AXI ID width

Ports:
- clock  in  1  single clock for all logic
- reset  in  1  asynchronous, active-high
- s_ar_{valid,addr,len,size,burst,id} in / s_ar_ready out  1,ADDR_W,8,3,2,ID_W / 1  upstream read address
- s_r_{valid,data,resp,id,last} out / s_r_ready in  1,DATA_W,2,ID_W,1 / 1  upstream read data
- s_aw_{valid,addr,len,size,burst,id} in / s_aw_ready out  as AR  upstream write address
- s_w_{valid,data,strb,last} in / s_w_ready out  1,DATA_W,DATA_W/8,1 / 1  upstream write data
- s_b_{valid,resp,id} out / s_b_ready in  1,2,ID_W / 1  upstream write response
- m_ar_*, m_r_*, m_aw_*, m_w_*, m_b_*  mirror of s_* with direction reversed; m_ar_len/m_aw_len always 0, m_*_burst always INCR, m_w_last always 1
- protocol_err  out  1  sticky; set on upstream wlast mismatch, cleared only by reset

## Operation
- Read and write paths are independent FSMs. Each has at most one upstream burst and one downstream beat in flight.
- Read FSM: R_IDLE -> R_ISSUE -> R_WAIT -> R_RET, then back to R_ISSUE, or to R_IDLE after the final beat.
  - R_IDLE: s_ar_ready=1. On handshake, latch addr, len, size, burst, id; set beat counter=0.
  - R_ISSUE: m_ar_valid=1 with the current address.
  - R_WAIT: m_r_ready=1. Capture data and resp.
  - R_RET: s_r_valid=1, s_r_id = latched id, s_r_last = (count==len). On s_r handshake, advance the address and count.
- Write FSM: W_IDLE -> W_AW -> W_WCAP -> W_WPUSH -> W_B, then back to W_AW, or to W_RESP after the final beat; W_RESP -> W_IDLE.
  - W_WCAP: s_w_ready=1. Capture data and strb. Check s_w_last against (count==len); a mismatch sets protocol_err, and the beat count from len still governs.
  - W_B: m_b_ready=1. Merge resp into the accumulator as the numeric max, so DECERR(3) > SLVERR(2) > OKAY(0). The accumulator resets to 0 per burst.
  - W_RESP: s_b_valid=1 with the merged resp and the latched id.
- Address advance by burst type:
  - FIXED: address unchanged.
  - INCR (and reserved 2'b11): addr += 1<<size, ADDR_W-bit wrap-around.
  - WRAP: see Configuration.
- Downstream m_*_size equals the latched size. Downstream IDs equal the latched upstream ID.
- Downstream resp values are passed per beat on R unmodified.

## Timing
- All outputs are registered or decoded from registered state; no combinational path from s_* to m_*.
- Reset (asynchronous assert, synchronous release via the shared reset): both FSMs go to IDLE.
  - All valid and ready outputs are 0 while reset is high.
  - s_ar_ready and s_aw_ready are 1 the first cycle after release.
  - protocol_err=0; accumulators and counters are 0.
- Read latency:
  - s_ar handshake at cycle N -> m_ar_valid at N+1.
  - m_r handshake at M -> s_r_valid at M+1.
  - s_r handshake at K -> next m_ar_valid at K+1.
- Write latency:
  - s_aw handshake at N -> m_aw_valid at N+1.
  - m_aw handshake -> s_w_ready next cycle.
  - s_w capture -> m_w_valid next cycle.
  - m_b handshake on the final beat -> s_b_valid next cycle.
- Valids hold with stable payload until handshake; stalls of any length on any ready are tolerated.
- Simultaneous AR and AW are accepted in the same cycle; the two paths never block each other.
- Reset mid-burst discards all in-flight state with no upstream response. Top shares the reset.

## Configuration
- PS_AXI_SPLIT_WRAP_EN defined: WRAP bursts advance as addr = (addr & ~mask) | ((addr + (1<<size)) & mask), where mask = ((len+1)<<size) - 1.
- PS_AXI_SPLIT_WRAP_EN undefined: WRAP is treated as INCR, and the wrap mask logic is not synthesized.

## Test plan
- INCR read: addr 0x1000, len 3, size 2, id 0x5A5. Required: 4 m_ar at 0x1000/0x1004/0x1008/0x100C, each with len 0; 4 s_r beats, id 0x5A5, rlast only on the 4th.
- FIXED write: addr 0x2000, len 1, strb 0xF. Required: two m_aw at 0x2000; m_w_last=1 on each; one s_b with OKAY.
- Response merge: 3-beat write with m_b resp OKAY, SLVERR, OKAY. Required: a single s_b with resp 2'b10.
- WRAP read, with the macro defined: addr 0x3038, len 3, size 3. Required: m_ar at 0x3038, 0x3020, 0x3028, 0x3030. With the macro undefined: 0x3038, 0x3040, 0x3048, 0x3050.
- wlast error: len 2 write with s_w_last high on beat 0. Required: protocol_err=1 from the next cycle and held; 3 beats still issued; s_b delivered.
- Backpressure plus reset: s_r_ready held low 10 cycles mid-burst. Required: s_r_valid and data stable throughout. Then assert reset during W_B: all valids drop immediately, and s_aw_ready=1 the cycle after release.
